// File: rtl/ntt_pkg.sv
// Shared NTT constants, loop-sequencer state type and stage-stepping helper.
package ntt_pkg;

  localparam int N_LOG2           = 10;
  localparam int NUM_STAGES       = 10;
  localparam int TUPLES_PER_STAGE = 256;
  localparam int K_W              = 8;
  localparam int I_W              = 8;
  localparam int P_W              = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } loop_state_t;

  // Forward transforms climb through the stages, inverse transforms descend.
  function automatic logic [P_W-1:0] next_stage(input logic [P_W-1:0] p_cur,
                                                input logic           desc);
    return desc ? (p_cur - 4'd1) : (p_cur + 4'd1);
  endfunction

endpackage

// File: rtl/ntt_stage_limits.sv
// Decodes a stage index into the last k (block) and last i (butterfly) index of that stage.
module ntt_stage_limits
  import ntt_pkg::*;
(
  input  logic [P_W-1:0] p,
  output logic [K_W-1:0] k_max,
  output logic [I_W-1:0] i_max
);

  logic [8:0] i_span;
  logic [8:0] k_span;

  // Stage 0 is a flat walk over 256 blocks; later stages trade blocks for butterflies.
  always_comb begin
    i_span = 9'd1;
    k_span = 9'd256;
    if ((p != '0) && (p < P_W'(NUM_STAGES))) begin
      i_span = 9'd1 << (p - 4'd1);
      k_span = 9'd1 << (4'd9 - p);
    end
    i_max = I_W'(i_span - 9'd1);
    k_max = K_W'(k_span - 9'd1);
  end

endmodule

// File: rtl/ntt_loop_ctrl.sv
// Per-stage (k,i,p) loop sequencer for the 1024-point, 2-BFU NTT datapath.
// Optional NTT_LOOP_INTT_EN adds an inv input that runs the stages in descending order.
module ntt_loop_ctrl
  import ntt_pkg::*;
#(
  parameter int STAGE_GAP = 2,
  parameter int N_LOG2    = ntt_pkg::N_LOG2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef NTT_LOOP_INTT_EN
  input  logic           inv,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K_W-1:0] k,
  output logic [I_W-1:0] i,
  output logic [P_W-1:0] p,
  output logic           stage_last,
  output logic           busy,
  output logic           done
);

  localparam logic [P_W-1:0] P_LAST   = P_W'(N_LOG2 - 1);
  localparam logic [3:0]     GAP_LAST = 4'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);

  loop_state_t    state;
  loop_state_t    state_nxt;
  logic [3:0]     gap_cnt;
  logic [K_W-1:0] k_max;
  logic [I_W-1:0] i_max;
  logic           at_last;
  logic           fire;
  logic           launch;
  logic [P_W-1:0] p_final;

  ntt_stage_limits u_limits (
    .p     (p),
    .k_max (k_max),
    .i_max (i_max)
  );

`ifdef NTT_LOOP_INTT_EN
  logic desc_r;
  logic start_desc;
  assign start_desc = inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_r <= 1'b0;
    end else if (launch) begin
      desc_r <= inv;
    end
  end
`else
  logic desc_r;
  logic start_desc;
  assign desc_r     = 1'b0;
  assign start_desc = 1'b0;
`endif

  assign launch  = (state == IDLE) && start;
  assign fire    = (state == RUN) && out_ready;
  assign at_last = (k == k_max) && (i == i_max);
  assign p_final = desc_r ? '0 : P_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (fire && at_last) begin
          if (p == p_final)        state_nxt = DONE;
          else if (STAGE_GAP == 0) state_nxt = RUN;
          else                     state_nxt = GAP;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == RUN);
    busy       = (state == RUN) || (state == GAP);
    done       = (state == DONE);
    stage_last = (state == RUN) && at_last;
  end

  // Gap length counts BFU drain cycles; the stage index has already moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + 4'd1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // i is the inner loop; k steps when i wraps; p steps after the stage's last tuple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      i <= '0;
      p <= '0;
    end else if (launch) begin
      k <= '0;
      i <= '0;
      p <= start_desc ? P_LAST : '0;
    end else if (fire) begin
      if (at_last) begin
        k <= '0;
        i <= '0;
        if (p != p_final) p <= next_stage(p, desc_r);
      end else if (i == i_max) begin
        i <= '0;
        k <= k + 8'd1;
      end else begin
        i <= i + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Self-checking bench for ntt_loop_ctrl against a loop-nest reference model.
module tb_ntt_loop_ctrl;
  import ntt_pkg::*;

  localparam int STAGE_GAP = 2;
  localparam int TOTAL     = NUM_STAGES * TUPLES_PER_STAGE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] k;
  logic [7:0] i;
  logic [3:0] p;
  logic       stage_last;
  logic       busy;
  logic       done;
`ifdef NTT_LOOP_INTT_EN
  logic       inv = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  int exp_k [TOTAL];
  int exp_i [TOTAL];
  int exp_p [TOTAL];
  bit exp_last [TOTAL];
  int obs_k [TOTAL];
  int obs_i [TOTAL];
  int obs_p [TOTAL];
  bit obs_last [TOTAL];
  int stage_fires [NUM_STAGES];

  always #5 clk = ~clk;

  ntt_loop_ctrl #(.STAGE_GAP(STAGE_GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef NTT_LOOP_INTT_EN
    .inv        (inv),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .k          (k),
    .i          (i),
    .p          (p),
    .stage_last (stage_last),
    .busy       (busy),
    .done       (done)
  );

  // Reference: nested loops over stages, k outer, i inner.
  task automatic build_expected(input bit desc);
    int n = 0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      int pp;
      int icnt;
      int kcnt;
      pp   = desc ? (NUM_STAGES - 1 - s) : s;
      icnt = (pp == 0) ? 1 : (1 << (pp - 1));
      kcnt = TUPLES_PER_STAGE / icnt;
      for (int kk = 0; kk < kcnt; kk++) begin
        for (int ii = 0; ii < icnt; ii++) begin
          exp_k[n]    = kk;
          exp_i[n]    = ii;
          exp_p[n]    = pp;
          exp_last[n] = (kk == kcnt - 1) && (ii == icnt - 1);
          n++;
        end
      end
    end
  endtask

  task automatic run_transform(input int ready_pct, input int start_again_at, input bit desc);
    int   idx = 0;
    int   last_fire_cyc = -10;
    int   gap_len = 0;
    int   dones = 0;
    bit   in_gap = 0;
    bit   timed_out = 1;
    bit   prev_valid = 0;
    bit   prev_ready = 0;
    logic [7:0] pk = '0;
    logic [7:0] pi = '0;
    logic [3:0] pp = '0;
    build_expected(desc);
    foreach (stage_fires[s]) stage_fires[s] = 0;
    @(posedge clk); #1;
`ifdef NTT_LOOP_INTT_EN
    inv = desc;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (cyc != last_fire_cyc + 1) begin
          errors++;
          $display("FAIL done_latency: done at cycle %0d want %0d", cyc, last_fire_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_flags: busy=%b valid=%b want 0 0", busy, out_valid);
        end
        timed_out = 0;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_run: cycle %0d got %b want 1", cyc, busy);
      end
      if (out_valid === 1'b1) begin
        if (in_gap) begin
          checks++;
          if (gap_len != STAGE_GAP) begin
            errors++;
            $display("FAIL stage_gap: got %0d idle cycles want %0d", gap_len, STAGE_GAP);
          end
          in_gap = 0;
        end
        if (prev_valid && !prev_ready) begin
          checks++;
          if ({k, i, p} !== {pk, pi, pp}) begin
            errors++;
            $display("FAIL hold: got k=%0d i=%0d p=%0d want k=%0d i=%0d p=%0d", k, i, p, pk, pi, pp);
          end
        end
        checks++;
        if (idx >= TOTAL) begin
          errors++;
          $display("FAIL extra_tuple: k=%0d i=%0d p=%0d after %0d tuples", k, i, p, TOTAL);
        end else if (k !== exp_k[idx][7:0] || i !== exp_i[idx][7:0] || p !== exp_p[idx][3:0]
                     || stage_last !== exp_last[idx]) begin
          errors++;
          $display("FAIL tuple[%0d]: got k=%0d i=%0d p=%0d last=%b want k=%0d i=%0d p=%0d last=%b",
                   idx, k, i, p, stage_last, exp_k[idx], exp_i[idx], exp_p[idx], exp_last[idx]);
        end
      end else if (in_gap) begin
        gap_len++;
      end else begin
        checks++;
        errors++;
        $display("FAIL valid_drop: cycle %0d got valid=%b want 1 at tuple %0d", cyc, out_valid, idx);
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      start = (start_again_at >= 0) && (idx == start_again_at);
      prev_valid = (out_valid === 1'b1);
      prev_ready = out_ready;
      pk = k;
      pi = i;
      pp = p;
      if (out_valid === 1'b1 && out_ready) begin
        if (idx < TOTAL) begin
          obs_k[idx]    = k;
          obs_i[idx]    = i;
          obs_p[idx]    = p;
          obs_last[idx] = stage_last;
          if (exp_last[idx] && idx + 1 < TOTAL) begin
            in_gap  = 1;
            gap_len = 0;
          end
        end
        if (p < NUM_STAGES) stage_fires[p]++;
        idx++;
        last_fire_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL timeout: no done after %0d tuples", idx);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_count: got %0d want 1", dones);
    end
    checks++;
    if (idx != TOTAL) begin
      errors++;
      $display("FAIL fire_count: got %0d want %0d", idx, TOTAL);
    end
    for (int s = 0; s < NUM_STAGES; s++) begin
      checks++;
      if (stage_fires[s] != TUPLES_PER_STAGE) begin
        errors++;
        $display("FAIL stage_fires[%0d]: got %0d want %0d", s, stage_fires[s], TUPLES_PER_STAGE);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, done, stage_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/done/last=%b%b%b%b want 0000",
               out_valid, busy, done, stage_last);
    end
    checks++;
    if ({k, i, p} !== 20'd0) begin
      errors++;
      $display("FAIL reset_idx: got k=%0d i=%0d p=%0d want 0 0 0", k, i, p);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_full_run();
    run_transform(100, -1, 1'b0);
  endtask

  task automatic test_ordering();
    int want_k [6] = '{0, 0, 0, 0, 1, 63};
    int want_i [6] = '{0, 1, 2, 3, 0, 3};
    int at     [6] = '{768, 769, 770, 771, 772, 1023};
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (obs_k[at[n]] != want_k[n] || obs_i[at[n]] != want_i[n] || obs_p[at[n]] != 3) begin
        errors++;
        $display("FAIL order_p3[%0d]: got (%0d,%0d) p=%0d want (%0d,%0d) p=3",
                 at[n], obs_k[at[n]], obs_i[at[n]], obs_p[at[n]], want_k[n], want_i[n]);
      end
    end
    checks++;
    if (obs_last[1023] != 1'b1 || obs_last[1022] != 1'b0) begin
      errors++;
      $display("FAIL order_p3_last: got last=%b prev=%b want 1 0", obs_last[1023], obs_last[1022]);
    end
    checks++;
    if (obs_k[TOTAL-1] != 0 || obs_i[TOTAL-1] != 255 || obs_p[TOTAL-1] != 9 || obs_last[TOTAL-1] != 1'b1) begin
      errors++;
      $display("FAIL order_p9_last: got (%0d,%0d) p=%0d last=%b want (0,255) p=9 last=1",
               obs_k[TOTAL-1], obs_i[TOTAL-1], obs_p[TOTAL-1], obs_last[TOTAL-1]);
    end
  endtask

  task automatic test_backpressure();
    run_transform(30, -1, 1'b0);
  endtask

  task automatic test_start_busy();
    run_transform(100, 100, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    int dones = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (out_valid === 1'b1 && p == 4'd4 && k >= 8'd3) begin
        reached = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reach_p4: never reached stage 4, p=%0d", p);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || {k, i, p} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b k=%0d i=%0d p=%0d want 0 0 0 0 0",
               out_valid, busy, k, i, p);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1 || out_valid === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done/valid cycles want 0", dones);
    end
  endtask

`ifdef NTT_LOOP_INTT_EN
  task automatic test_inverse();
    run_transform(100, -1, 1'b1);
    checks++;
    if (obs_p[0] != 9 || obs_k[0] != 0 || obs_i[0] != 0) begin
      errors++;
      $display("FAIL inv_first: got (%0d,%0d) p=%0d want (0,0) p=9", obs_k[0], obs_i[0], obs_p[0]);
    end
    checks++;
    if (obs_p[TOTAL-1] != 0 || obs_k[TOTAL-1] != 255 || obs_last[TOTAL-1] != 1'b1) begin
      errors++;
      $display("FAIL inv_last: got k=%0d p=%0d last=%b want k=255 p=0 last=1",
               obs_k[TOTAL-1], obs_p[TOTAL-1], obs_last[TOTAL-1]);
    end
    inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_ordering();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
`ifdef NTT_LOOP_INTT_EN
    test_inverse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
